// File: rtl/ps2_joy_pkg.sv
// rtl/ps2_joy_pkg.sv - scan codes, joystick bit indices, prefix states and key map for the PS/2 joystick decoder
package ps2_joy_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_F3    = 8'h04;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_ALT   = 8'h11;
    localparam logic [7:0] SC_ESC   = 8'h76;

    localparam logic [3:0] JB_FIRE   = 4'd0;
    localparam logic [3:0] JB_START1 = 4'd1;
    localparam logic [3:0] JB_START2 = 4'd2;
    localparam logic [3:0] JB_COIN   = 4'd3;
    localparam logic [3:0] JB_UP     = 4'd4;
    localparam logic [3:0] JB_DOWN   = 4'd5;
    localparam logic [3:0] JB_LEFT   = 4'd6;
    localparam logic [3:0] JB_RIGHT  = 4'd7;
    localparam logic [3:0] JB_BOMB   = 4'd8;
    localparam logic [3:0] JB_ESC    = 4'd9;

    // Bytes following E1 in the Pause make sequence that must not be decoded as keys.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} prefix_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_hit_t;

    // Arrows and ctrl map with or without E0; the other keys only without it.
    function automatic key_hit_t map_key(input logic [7:0] code, input logic ext);
        key_hit_t k;
        k.hit = !ext;
        k.idx = JB_FIRE;
        case (code)
            SC_SPACE:     k.idx = JB_FIRE;
            SC_1, SC_F1:  k.idx = JB_START1;
            SC_2, SC_F2:  k.idx = JB_START2;
            SC_5, SC_F3:  k.idx = JB_COIN;
            SC_ALT:       k.idx = JB_BOMB;
            SC_ESC:       k.idx = JB_ESC;
            SC_UP:        begin k.hit = 1'b1; k.idx = JB_UP;    end
            SC_DOWN:      begin k.hit = 1'b1; k.idx = JB_DOWN;  end
            SC_LEFT:      begin k.hit = 1'b1; k.idx = JB_LEFT;  end
            SC_RIGHT:     begin k.hit = 1'b1; k.idx = JB_RIGHT; end
            SC_CTRL:      begin k.hit = 1'b1; k.idx = JB_BOMB;  end
            default:      k.hit = 1'b0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host receiver: sync, glitch filter, 11-bit deframer, timeout
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic [7:0] rx_byte
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic          clk_filt_q, clk_filt_d, data_filt_q, data_filt_d;
    logic [FW-1:0] clk_cnt_q, clk_cnt_d, data_cnt_q, data_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shift_q, shift_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          fall;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};

        // A filtered line flips only after FILTER_LEN consecutive disagreeing samples.
        clk_cnt_d  = '0;
        clk_filt_d = clk_filt_q;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (clk_cnt_q == FW'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
            else                                  clk_cnt_d  = clk_cnt_q + FW'(1);
        end
        data_cnt_d  = '0;
        data_filt_d = data_filt_q;
        if (data_sync_q[1] != data_filt_q) begin
            if (data_cnt_q == FW'(FILTER_LEN - 1)) data_filt_d = data_sync_q[1];
            else                                   data_cnt_d  = data_cnt_q + FW'(1);
        end

        fall = clk_filt_q & ~clk_filt_d;

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        idle_d    = '0;
        rx_valid  = 1'b0;
        rx_err    = 1'b0;
        rx_byte   = shift_q[7:0];
        if (fall) begin
            if (bit_cnt_q == 4'd0) begin
                if (data_filt_q) rx_err    = 1'b1;
                else             bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (data_filt_q && (^shift_q)) rx_valid = 1'b1;
                else                           rx_err   = 1'b1;
            end else begin
                shift_d   = {data_filt_q, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            // A stalled partial frame is dropped quietly so the next start bit resyncs.
            if (idle_q == TW'(TIMEOUT - 1)) bit_cnt_d = 4'd0;
            else                            idle_d    = idle_q + TW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_filt_q  <= 1'b1;
            data_filt_q <= 1'b1;
            clk_cnt_q   <= '0;
            data_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            idle_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_filt_q  <= clk_filt_d;
            data_filt_q <= data_filt_d;
            clk_cnt_q   <= clk_cnt_d;
            data_cnt_q  <= data_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
        end
    end

endmodule

// File: rtl/ps2_joy_decoder.sv
// rtl/ps2_joy_decoder.sv - PS/2 keyboard to held-key joystick vector: prefix FSM, pause skip, key map
module ps2_joy_decoder
    import ps2_joy_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 24000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic [9:0] joystick,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic       rx_valid, rx_err;
    logic [7:0] rx_byte;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_kbd_clk),
        .ps2_data (ps2_kbd_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_byte  (rx_byte)
    );

    prefix_t    state_q, state_d;
    logic [2:0] skip_q, skip_d;
    logic [9:0] joy_q, joy_d;
    logic       valid_q, valid_d, err_q, err_d;
    logic [7:0] code_q, code_d;
    key_hit_t   key;

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        joy_d   = joy_q;
        valid_d = rx_valid;
        err_d   = rx_err;
        code_d  = rx_valid ? rx_byte : code_q;
        key     = map_key(rx_byte, (state_q == EXT) || (state_q == EXT_BRK));
        if (rx_err) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rx_byte == SC_E0)      state_d = EXT;
                        else if (rx_byte == SC_F0) state_d = BRK;
                        else if (rx_byte == SC_E1) skip_d  = PAUSE_SKIP;
                        else if (key.hit)          joy_d[key.idx] = 1'b1;
                    end
                    EXT: begin
                        if (rx_byte == SC_F0)      state_d = EXT_BRK;
                        else if (rx_byte != SC_E0) begin
                            state_d = IDLE;
                            if (key.hit) joy_d[key.idx] = 1'b1;
                        end
                    end
                    BRK, EXT_BRK: begin
                        state_d = IDLE;
                        if (key.hit) joy_d[key.idx] = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
            joy_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            joy_q   <= joy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign joystick   = joy_q;
    assign scan_valid = valid_q;
    assign scan_code  = code_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_joy_decoder.sv
// tb/tb_ps2_joy_decoder.sv - self-checking bench for ps2_joy_decoder with a byte-stream reference model
module tb_ps2_joy_decoder;

    localparam int TIMEOUT = 24000;
    localparam int HALF    = 20;
    localparam int NK      = 19;
    localparam logic [8:0] KM_KEY [NK] = '{
        9'h029, 9'h016, 9'h005, 9'h01E, 9'h006, 9'h02E, 9'h004,
        9'h175, 9'h172, 9'h16B, 9'h174, 9'h075, 9'h072, 9'h06B, 9'h074,
        9'h014, 9'h114, 9'h011, 9'h076};
    localparam int KM_BIT [NK] = '{0, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 4, 5, 6, 7, 8, 8, 8, 9};

    logic       clk_sys = 1'b0;
    logic       reset, ps2_kbd_clk, ps2_kbd_data;
    logic [9:0] joystick;
    logic       scan_valid, frame_err;
    logic [7:0] scan_code;

    int pass_cnt = 0;
    int total_cnt = 0;

    int         valid_hi = 0;
    int         err_hi = 0;
    logic [7:0] cap_code[$];
    logic [9:0] cap_joy[$];

    bit         m_ext, m_brk;
    int         m_skip;
    logic [9:0] m_joy;

    always #5 clk_sys = ~clk_sys;

    ps2_joy_decoder #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .joystick     (joystick),
        .scan_valid   (scan_valid),
        .scan_code    (scan_code),
        .frame_err    (frame_err)
    );

    always @(negedge clk_sys) begin
        if (scan_valid) begin
            valid_hi++;
            cap_code.push_back(scan_code);
            cap_joy.push_back(joystick);
        end
        if (frame_err) err_hi++;
    end

    function automatic int key_bit(input logic [7:0] c, input bit ext);
        for (int i = 0; i < NK; i++)
            if (KM_KEY[i] == {ext, c}) return KM_BIT[i];
        return -1;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_skip = 0; m_joy = '0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int k;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1 && !m_ext && !m_brk) m_skip = 7;
        else if (b == 8'hE0 && !m_brk) m_ext = 1;
        else if (b == 8'hF0 && !m_brk) m_brk = 1;
        else begin
            k = key_bit(b, m_ext);
            if (k >= 0) m_joy[k] = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_kbd_data = bits[i];
            wait_cyc(HALF);
            ps2_kbd_clk = 1'b0;
            wait_cyc(HALF);
            ps2_kbd_clk = 1'b1;
        end
        ps2_kbd_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        send_bits({1'b1, par, b, 1'b0}, 11);
        if (bad) begin m_ext = 0; m_brk = 0; end
        else model_byte(b);
    endtask

    task automatic test_reset();
        reset = 1'b1; ps2_kbd_clk = 1'b1; ps2_kbd_data = 1'b1;
        model_reset();
        wait_cyc(4);
        total_cnt++; if (joystick !== 10'h000) $display("FAIL reset_joy: got %h want 000", joystick); else pass_cnt++;
        total_cnt++; if (scan_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", scan_valid); else pass_cnt++;
        total_cnt++; if (scan_code !== 8'h00) $display("FAIL reset_code: got %h want 00", scan_code); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_err); else pass_cnt++;
        reset = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_fire();
        int v0 = valid_hi, e0 = err_hi, q0 = cap_joy.size();
        send_byte(8'h29, 0);
        total_cnt++; if (valid_hi - v0 !== 1) $display("FAIL fire_valid_cycles: got %0d want 1", valid_hi - v0); else pass_cnt++;
        total_cnt++; if (err_hi !== e0) $display("FAIL fire_err: got %0d want %0d", err_hi, e0); else pass_cnt++;
        total_cnt++; if (scan_code !== 8'h29) $display("FAIL fire_code: got %h want 29", scan_code); else pass_cnt++;
        total_cnt++; if (cap_joy.size() <= q0 || cap_joy[q0] !== 10'h001)
            $display("FAIL fire_joy_at_valid: got %h want 001", (cap_joy.size() > q0) ? cap_joy[q0] : 10'hxxx); else pass_cnt++;
        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);
        total_cnt++; if (joystick !== 10'h000) $display("FAIL fire_release: got %h want 000", joystick); else pass_cnt++;
    endtask

    task automatic test_ext_arrow();
        logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        logic [9:0] exp [5] = '{10'h000, 10'h010, 10'h010, 10'h010, 10'h000};
        int q0 = cap_joy.size();
        for (int i = 0; i < 5; i++) send_byte(seq[i], 0);
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (cap_joy.size() <= q0 + i || cap_joy[q0 + i] !== exp[i])
                $display("FAIL ext_arrow_byte%0d: got %h want %h", i,
                         (cap_joy.size() > q0 + i) ? cap_joy[q0 + i] : 10'hxxx, exp[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_parity_err();
        int v0, e0;
        send_byte(8'h16, 0);
        v0 = valid_hi; e0 = err_hi;
        send_byte(8'h2E, 1);
        total_cnt++; if (err_hi - e0 !== 1) $display("FAIL parity_err_cycles: got %0d want 1", err_hi - e0); else pass_cnt++;
        total_cnt++; if (valid_hi !== v0) $display("FAIL parity_no_valid: got %0d want %0d", valid_hi, v0); else pass_cnt++;
        total_cnt++; if (scan_code !== 8'h16) $display("FAIL parity_code_held: got %h want 16", scan_code); else pass_cnt++;
        total_cnt++; if (joystick !== 10'h002) $display("FAIL parity_joy_held: got %h want 002", joystick); else pass_cnt++;
        send_byte(8'h16, 1);
        send_byte(8'hF0, 0);
        send_byte(8'h16, 0);
        total_cnt++; if (joystick !== 10'h000) $display("FAIL parity_then_break: got %h want 000", joystick); else pass_cnt++;
        // a bad frame must drop a pending F0 so the next key is a make
        send_byte(8'hF0, 0);
        send_byte(8'h11, 1);
        send_byte(8'h29, 0);
        total_cnt++; if (joystick !== 10'h001) $display("FAIL err_clears_prefix: got %h want 001", joystick); else pass_cnt++;
        send_byte(8'hF0, 0);
        send_byte(8'h29, 0);
        // start bit sampled high is rejected on its own edge
        e0 = err_hi; v0 = valid_hi;
        send_bits(11'h001, 1);
        total_cnt++; if (err_hi - e0 !== 1) $display("FAIL start_err: got %0d want 1", err_hi - e0); else pass_cnt++;
        send_bits({1'b0, ~(^8'h76), 8'h76, 1'b0}, 11);
        m_ext = 0; m_brk = 0;
        total_cnt++; if (err_hi - e0 !== 2 || valid_hi !== v0) $display("FAIL stop_err: got err %0d valid %0d want 2 0", err_hi - e0, valid_hi - v0); else pass_cnt++;
        send_byte(8'h76, 0);
        total_cnt++; if (joystick !== 10'h200) $display("FAIL after_start_err: got %h want 200", joystick); else pass_cnt++;
        send_byte(8'hF0, 0);
        send_byte(8'h76, 0);
    endtask

    task automatic test_timeout();
        int e0 = err_hi, v0 = valid_hi;
        logic [7:0] b = 8'h1E;
        send_bits({1'b1, ~(^b), b, 1'b0}, 6);
        wait_cyc(TIMEOUT + 10);
        send_byte(b, 0);
        total_cnt++; if (err_hi !== e0) $display("FAIL timeout_no_err: got %0d want %0d", err_hi, e0); else pass_cnt++;
        total_cnt++; if (valid_hi - v0 !== 1) $display("FAIL timeout_valid: got %0d want 1", valid_hi - v0); else pass_cnt++;
        total_cnt++; if (joystick !== 10'h004) $display("FAIL timeout_joy: got %h want 004", joystick); else pass_cnt++;
        send_byte(8'hF0, 0);
        send_byte(b, 0);
    endtask

    task automatic test_pause_skip();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        int q0 = cap_joy.size();
        for (int i = 0; i < 8; i++) send_byte(seq[i], 0);
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if (cap_joy.size() <= q0 + i || cap_joy[q0 + i] !== 10'h000)
                $display("FAIL pause_byte%0d: got %h want 000", i, (cap_joy.size() > q0 + i) ? cap_joy[q0 + i] : 10'hxxx);
            else pass_cnt++;
        end
        send_byte(8'h2E, 0);
        total_cnt++; if (joystick !== 10'h008) $display("FAIL pause_then_coin: got %h want 008", joystick); else pass_cnt++;
        send_byte(8'hF0, 0);
        send_byte(8'h2E, 0);
    endtask

    task automatic test_glitch_reset();
        int v0 = valid_hi, e0 = err_hi;
        logic [7:0] b = 8'h75;
        for (int i = 0; i < 4; i++) begin
            ps2_kbd_data = 1'b0;
            ps2_kbd_clk = 1'b0;
            wait_cyc(3);
            ps2_kbd_clk = 1'b1;
            wait_cyc(HALF);
        end
        ps2_kbd_data = 1'b1;
        wait_cyc(HALF);
        send_byte(8'h29, 0);
        total_cnt++; if (valid_hi - v0 !== 1 || err_hi !== e0) $display("FAIL glitch_frame: got valid %0d err %0d want 1 0", valid_hi - v0, err_hi - e0); else pass_cnt++;
        total_cnt++; if (scan_code !== 8'h29 || joystick !== 10'h001) $display("FAIL glitch_decode: got %h/%h want 29/001", scan_code, joystick); else pass_cnt++;
        v0 = valid_hi; e0 = err_hi;
        send_bits({1'b1, ~(^b), b, 1'b0}, 6);
        reset = 1'b1;
        wait_cyc(3);
        total_cnt++; if ({joystick, scan_valid, scan_code, frame_err} !== 20'h0)
            $display("FAIL reset_midframe: got %h/%b/%h/%b want all 0", joystick, scan_valid, scan_code, frame_err); else pass_cnt++;
        reset = 1'b0;
        model_reset();
        wait_cyc(HALF);
        send_byte(8'h16, 0);
        total_cnt++; if (valid_hi - v0 !== 1 || err_hi !== e0) $display("FAIL post_reset_frame: got valid %0d err %0d want 1 0", valid_hi - v0, err_hi - e0); else pass_cnt++;
        total_cnt++; if (joystick !== 10'h002 || scan_code !== 8'h16) $display("FAIL post_reset_decode: got %h/%h want 002/16", joystick, scan_code); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit bad;
        int pick, v0, e0, q0;
        for (int n = 0; n < 30; n++) begin
            pick = $urandom_range(0, 9);
            bad = (pick == 9);
            if (pick <= 5)      b = KM_KEY[$urandom_range(0, NK - 1)][7:0];
            else if (pick == 6) b = 8'hF0;
            else if (pick == 7) b = 8'hE0;
            else                b = 8'($urandom_range(0, 255));
            v0 = valid_hi; e0 = err_hi; q0 = cap_joy.size();
            send_byte(b, bad);
            total_cnt++;
            if (bad) begin
                if (err_hi - e0 !== 1 || valid_hi !== v0)
                    $display("FAIL rand%0d_err: byte %h got err %0d valid %0d want 1 0", n, b, err_hi - e0, valid_hi - v0);
                else pass_cnt++;
            end else begin
                if (valid_hi - v0 !== 1 || cap_joy.size() <= q0 || cap_code[q0] !== b || cap_joy[q0] !== m_joy)
                    $display("FAIL rand%0d_byte: byte %h got code %h joy %h want %h %h", n, b,
                             (cap_code.size() > q0) ? cap_code[q0] : 8'hxx,
                             (cap_joy.size() > q0) ? cap_joy[q0] : 10'hxxx, b, m_joy);
                else pass_cnt++;
            end
        end
        total_cnt++; if (joystick !== m_joy) $display("FAIL rand_final: got %h want %h", joystick, m_joy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_fire();
        test_ext_arrow();
        test_parity_err();
        test_timeout();
        test_pause_skip();
        test_glitch_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
